lamp_fpu_issue_ctrl: RTL and testbench

Single-issue sequencer in front of the lampFPU execution units (add, sub, mul, div, sqrt, f2i, i2f). It accepts one operation at a time from the core and pulses the matching unit's start strobe. It then waits for that unit's valid, captures the result and flags, and returns them with a one-cycle valid pulse. A watchdog aborts any operation whose unit fails to respond.

---
 rtl/lamp_fpu_issue_ctrl_pkg.sv | 41 ++++
 rtl/lamp_fpu_issue_ctrl_watchdog.sv | 38 +++
 rtl/lamp_fpu_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_lamp_fpu_issue_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lamp_fpu_issue_ctrl_pkg.sv
// Shared types and constants for the lampFPU issue controller.
// Opcode/unit numbering here is the same index used for do_o and unitValid_i.
package lamp_fpu_issue_ctrl_pkg;

    localparam int LAMP_FPU_NUM_UNITS = 7;

    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIVZERO   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [2:0] {
        FPU_ADD  = 3'd0,
        FPU_SUB  = 3'd1,
        FPU_MUL  = 3'd2,
        FPU_DIV  = 3'd3,
        FPU_SQRT = 3'd4,
        FPU_F2I  = 3'd5,
        FPU_I2F  = 3'd6,
        FPU_RSVD = 3'd7
    } fpu_op_e;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_ISSUE = 2'd1,
        CTRL_WAIT  = 2'd2,
        CTRL_RESP  = 2'd3
    } ctrl_state_e;

    // One-hot start strobe for an opcode; the reserved opcode maps to no unit.
    function automatic logic [LAMP_FPU_NUM_UNITS-1:0] unit_onehot(input fpu_op_e op);
        logic [LAMP_FPU_NUM_UNITS-1:0] oh;
        oh = '0;
        if (op != FPU_RSVD) begin
            oh[op] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/lamp_fpu_issue_ctrl_watchdog.sv
// Watchdog counter for the issue controller: clear, count-enable and terminal flag.
// It saturates at TIMEOUT_CYCLES-1 so the controller can abort at the terminal count.
module lamp_fpu_ctrl_watchdog #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign terminal_o = (cnt_q == TERMINAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !terminal_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lamp_fpu_issue_ctrl.sv
// Single-issue sequencer in front of the lampFPU execution units.
// Strobes one unit, waits for its valid (or the watchdog), returns a one-cycle response.
module lamp_fpu_issue_ctrl
    import lamp_fpu_issue_ctrl_pkg::*;
#(
    parameter int RES_DW         = 16,
    parameter int FLAG_DW        = 5,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    doOp_i,
    input  logic [2:0]                              opcode_i,
    output logic                                    ready_o,
    output logic                                    busy_o,
    output logic [LAMP_FPU_NUM_UNITS-1:0]           do_o,
    input  logic [LAMP_FPU_NUM_UNITS-1:0]           unitValid_i,
    input  logic [LAMP_FPU_NUM_UNITS*RES_DW-1:0]    unitRes_i,
    input  logic [LAMP_FPU_NUM_UNITS*FLAG_DW-1:0]   unitFlags_i,
    output logic [RES_DW-1:0]                       res_o,
    output logic [FLAG_DW-1:0]                      flags_o,
    output logic                                    valid_o,
    output logic                                    timeout_o
);

    localparam logic [FLAG_DW-1:0] FLAGS_INVALID = {{(FLAG_DW-1){1'b0}}, 1'b1} << FLAG_INVALID;

    ctrl_state_e                    state_q, state_d;
    fpu_op_e                        cur_op_q, cur_op_d;
    logic [LAMP_FPU_NUM_UNITS-1:0]  do_q, do_d;
    logic [RES_DW-1:0]              res_q, res_d;
    logic [FLAG_DW-1:0]             flags_q, flags_d;
    logic                           valid_q, valid_d;
    logic                           timeout_q, timeout_d;

    fpu_op_e                        req_op;
    logic                           accept;
    logic                           unit_hit;
    logic [RES_DW-1:0]              unit_res;
    logic [FLAG_DW-1:0]             unit_flags;
    logic                           wd_clear;
    logic                           wd_enable;
    logic                           wd_terminal;

    assign req_op    = fpu_op_e'(opcode_i);
    assign ready_o   = (state_q == CTRL_IDLE) || (state_q == CTRL_RESP);
    assign busy_o    = (state_q == CTRL_ISSUE) || (state_q == CTRL_WAIT);
    assign accept    = doOp_i && ready_o;

    assign do_o      = do_q;
    assign res_o     = res_q;
    assign flags_o   = flags_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

    // Only the unit that owns the current operation can complete it.
    assign unit_hit   = unitValid_i[cur_op_q];
    assign unit_res   = unitRes_i[int'(cur_op_q)*RES_DW +: RES_DW];
    assign unit_flags = unitFlags_i[int'(cur_op_q)*FLAG_DW +: FLAG_DW];

    lamp_fpu_ctrl_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (wd_clear),
        .enable_i   (wd_enable),
        .terminal_o (wd_terminal)
    );

    always_comb begin
        state_d   = state_q;
        cur_op_d  = cur_op_q;
        res_d     = res_q;
        flags_d   = flags_q;
        do_d      = '0;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;

        case (state_q)
            CTRL_IDLE, CTRL_RESP: begin
                // RESP accepts like IDLE so a new op overlaps the response cycle.
                if (accept) begin
                    if (req_op == FPU_RSVD) begin
                        state_d = CTRL_RESP;
                        res_d   = '0;
                        flags_d = FLAGS_INVALID;
                        valid_d = 1'b1;
                    end else begin
                        state_d  = CTRL_ISSUE;
                        cur_op_d = req_op;
                        do_d     = unit_onehot(req_op);
                        wd_clear = 1'b1;
                    end
                end else if (state_q == CTRL_RESP) begin
                    state_d = CTRL_IDLE;
                end
            end
            CTRL_ISSUE, CTRL_WAIT: begin
                if (unit_hit) begin
                    state_d = CTRL_RESP;
                    res_d   = unit_res;
                    flags_d = unit_flags;
                    valid_d = 1'b1;
                end else if (wd_terminal) begin
                    state_d   = CTRL_RESP;
                    res_d     = '0;
                    flags_d   = FLAGS_INVALID;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    state_d   = CTRL_WAIT;
                    wd_enable = 1'b1;
                end
            end
            default: begin
                state_d = CTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CTRL_IDLE;
            cur_op_q  <= FPU_ADD;
            do_q      <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_op_q  <= cur_op_d;
            do_q      <= do_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_lamp_fpu_issue_ctrl.sv
// Self-checking bench for lamp_fpu_issue_ctrl: directed scenarios plus random ops
// checked cycle by cycle against a transaction-level latency/result model.
module tb_lamp_fpu_issue_ctrl;

    localparam int RES_DW  = 16;
    localparam int FLAG_DW = 5;
    localparam int TC      = 32;
    localparam int NU      = 7;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   doOp_i;
    logic [2:0]             opcode_i;
    logic                   ready_o;
    logic                   busy_o;
    logic [NU-1:0]          do_o;
    logic [NU-1:0]          unitValid_i;
    logic [NU*RES_DW-1:0]   unitRes_i;
    logic [NU*FLAG_DW-1:0]  unitFlags_i;
    logic [RES_DW-1:0]      res_o;
    logic [FLAG_DW-1:0]     flags_o;
    logic                   valid_o;
    logic                   timeout_o;

    int totalChecks = 0;
    int badChecks   = 0;

    always #5 clk = ~clk;

    lamp_fpu_issue_ctrl #(
        .RES_DW         (RES_DW),
        .FLAG_DW        (FLAG_DW),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .doOp_i      (doOp_i),
        .opcode_i    (opcode_i),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .do_o        (do_o),
        .unitValid_i (unitValid_i),
        .unitRes_i   (unitRes_i),
        .unitFlags_i (unitFlags_i),
        .res_o       (res_o),
        .flags_o     (flags_o),
        .valid_o     (valid_o),
        .timeout_o   (timeout_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Random results everywhere, random valids on units other than op; op's valid only on hit.
    task automatic driveUnits(input int op, input bit hit, input logic [15:0] r, input logic [4:0] f);
        logic [NU-1:0] mask;
        for (int k = 0; k < NU; k++) begin
            unitRes_i[k*RES_DW +: RES_DW]    = RES_DW'($urandom);
            unitFlags_i[k*FLAG_DW +: FLAG_DW] = FLAG_DW'($urandom);
        end
        mask = NU'($urandom_range(0, 127));
        if (op < NU) begin
            mask[op] = hit;
            unitRes_i[op*RES_DW +: RES_DW]    = r;
            unitFlags_i[op*FLAG_DW +: FLAG_DW] = f;
        end
        unitValid_i = mask;
    endtask

    // One operation: lat<0 means the unit never answers. Ends at the negedge of the response
    // cycle so the next call can issue back-to-back from RESP.
    task automatic applyStimulus(input int op, input int lat, input logic [15:0] r, input logic [4:0] f);
        int            expN;
        logic [NU-1:0] oh;
        logic [15:0]   expRes;
        logic [4:0]    expFlags;
        logic          expTimeout;
        oh = '0;
        if (op < NU) oh[op] = 1'b1;
        if (op == 7) begin
            expN = 1; expRes = '0; expFlags = 5'b10000; expTimeout = 1'b0;
        end else if (lat < 0) begin
            expN = TC + 1; expRes = '0; expFlags = 5'b10000; expTimeout = 1'b1;
        end else begin
            expN = lat + 2; expRes = r; expFlags = f; expTimeout = 1'b0;
        end
        checkOutput("ready_at_request", 32'(ready_o), 32'd1);
        doOp_i   = 1'b1;
        opcode_i = 3'(op);
        @(posedge clk);
        for (int n = 1; n <= expN; n++) begin
            @(negedge clk);
            doOp_i = 1'b0;
            checkOutput("do_strobe", 32'(do_o), 32'((n == 1) ? oh : '0));
            if (n < expN) begin
                checkOutput("valid_early", 32'(valid_o), 32'd0);
                checkOutput("busy_inflight", 32'(busy_o), 32'd1);
                checkOutput("ready_inflight", 32'(ready_o), 32'd0);
            end else begin
                checkOutput("valid_resp", 32'(valid_o), 32'd1);
                checkOutput("res_resp", 32'(res_o), 32'(expRes));
                checkOutput("flags_resp", 32'(flags_o), 32'(expFlags));
                checkOutput("timeout_resp", 32'(timeout_o), 32'(expTimeout));
                checkOutput("ready_resp", 32'(ready_o), 32'd1);
                checkOutput("busy_resp", 32'(busy_o), 32'd0);
            end
            driveUnits(op, (lat >= 0) && (n == 1 + lat), r, f);
        end
    endtask

    task automatic idleCycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            checkOutput("idle_valid", 32'(valid_o), 32'd0);
            checkOutput("idle_ready", 32'(ready_o), 32'd1);
            checkOutput("idle_busy", 32'(busy_o), 32'd0);
            checkOutput("idle_do", 32'(do_o), 32'd0);
            driveUnits(7, 1'b0, '0, '0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] hung");
    end

    initial begin
        int op, lat, gap;
        rst         = 1'b1;
        doOp_i      = 1'b0;
        opcode_i    = '0;
        unitValid_i = '0;
        unitRes_i   = '0;
        unitFlags_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_do", 32'(do_o), 32'd0);
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_timeout", 32'(timeout_o), 32'd0);
        checkOutput("rst_res", 32'(res_o), 32'd0);
        checkOutput("rst_flags", 32'(flags_o), 32'd0);
        checkOutput("rst_ready", 32'(ready_o), 32'd1);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        idleCycles(1);

        $display("[TB] f2i latency 1");
        applyStimulus(5, 1, 16'h0042, 5'b00000);
        idleCycles(1);
        $display("[TB] sqrt latency 12 with foreign valids");
        applyStimulus(4, 12, 16'h3f80, 5'b00001);
        idleCycles(2);
        $display("[TB] div never answered");
        applyStimulus(3, -1, 16'h1234, 5'b00000);
        idleCycles(1);
        $display("[TB] reserved opcode");
        applyStimulus(7, 0, 16'h0000, 5'b00000);
        idleCycles(1);
        $display("[TB] back-to-back mul then add");
        applyStimulus(2, 1, 16'h4040, 5'b00100);
        applyStimulus(0, 1, 16'hc000, 5'b00010);
        idleCycles(1);

        $display("[TB] reset during wait");
        applyStimulus(6, 0, 16'h4100, 5'b01000);
        idleCycles(1);
        doOp_i   = 1'b1;
        opcode_i = 3'd3;
        @(posedge clk);
        @(negedge clk);
        doOp_i = 1'b0;
        driveUnits(3, 1'b0, 16'hdead, 5'b11111);
        repeat (2) begin
            @(negedge clk);
            driveUnits(3, 1'b0, 16'hdead, 5'b11111);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_do", 32'(do_o), 32'd0);
        checkOutput("midrst_valid", 32'(valid_o), 32'd0);
        checkOutput("midrst_timeout", 32'(timeout_o), 32'd0);
        checkOutput("midrst_res", 32'(res_o), 32'd0);
        checkOutput("midrst_flags", 32'(flags_o), 32'd0);
        checkOutput("midrst_ready", 32'(ready_o), 32'd1);
        checkOutput("midrst_busy", 32'(busy_o), 32'd0);
        unitValid_i = 7'b0001000;
        unitRes_i[3*RES_DW +: RES_DW] = 16'hbeef;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            unitValid_i = '0;
            checkOutput("stale_valid", 32'(valid_o), 32'd0);
            checkOutput("stale_res", 32'(res_o), 32'd0);
        end
        applyStimulus(1, 3, 16'h5a5a, 5'b00011);
        idleCycles(1);

        $display("[TB] random operations");
        for (int t = 0; t < 30; t++) begin
            op  = $urandom_range(0, 7);
            lat = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 10);
            applyStimulus(op, lat, 16'($urandom), 5'($urandom));
            gap = $urandom_range(0, 2);
            idleCycles(gap);
        end
        idleCycles(1);
        unitValid_i = '0;

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
